// File: rtl/mux4_1_sel_if.sv
// Bus bundle for mux4_1_sel: data inputs, select, capture enable and outputs.
// Optional one-hot select output present when MUX4_1_SEL_ONEHOT_EN is defined.
interface mux4_1_sel_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       sel_q;
`ifdef MUX4_1_SEL_ONEHOT_EN
  logic [3:0]       sel_oh;
`endif

  modport master (
    output en, d0, d1, d2, d3, sel,
    input  y, y_q, sel_q
`ifdef MUX4_1_SEL_ONEHOT_EN
    , input sel_oh
`endif
  );

  modport slave (
    input  en, d0, d1, d2, d3, sel,
    output y, y_q, sel_q
`ifdef MUX4_1_SEL_ONEHOT_EN
    , output sel_oh
`endif
  );
endinterface

// File: rtl/mux4_1_sel.sv
// 4-to-1 mux with zero-latency output y plus registered copy y_q/sel_q.
// Define MUX4_1_SEL_ONEHOT_EN to add the combinational one-hot select output sel_oh.
module mux4_1_sel #(
  parameter int unsigned WIDTH = 4
) (
  input logic        clk,
  input logic        rst,
  mux4_1_sel_if.slave bus
);

  // Case selection keeps X on unselected inputs out of y; unknown sel yields all-X.
  always_comb begin
    bus.y = {WIDTH{1'bx}};
    case (bus.sel)
      2'd0:    bus.y = bus.d0;
      2'd1:    bus.y = bus.d1;
      2'd2:    bus.y = bus.d2;
      2'd3:    bus.y = bus.d3;
      default: bus.y = {WIDTH{1'bx}};
    endcase
  end

  // Pipelined copy for downstream consumers; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y_q   <= '0;
      bus.sel_q <= 2'd0;
    end else if (bus.en) begin
      bus.y_q   <= bus.y;
      bus.sel_q <= bus.sel;
    end
  end

`ifdef MUX4_1_SEL_ONEHOT_EN
  always_comb begin
    bus.sel_oh = 4'bxxxx;
    case (bus.sel)
      2'd0:    bus.sel_oh = 4'b0001;
      2'd1:    bus.sel_oh = 4'b0010;
      2'd2:    bus.sel_oh = 4'b0100;
      2'd3:    bus.sel_oh = 4'b1000;
      default: bus.sel_oh = 4'bxxxx;
    endcase
  end
`endif

endmodule

// File: tb/tb_mux4_1_sel.sv
// Self-checking bench for mux4_1_sel: vector table for the combinational path,
// scoreboard queue for the registered outputs.
module tb_mux4_1_sel;
  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  mux4_1_sel_if #(.WIDTH(W)) bus ();

  mux4_1_sel #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] sel;
    logic [W-1:0] d0, d1, d2, d3;
    logic [W-1:0] exp_y;
  } vec_t;

  typedef struct {
    logic [W-1:0] y_q;
    logic [1:0]   sel_q;
  } reg_exp_t;

  vec_t     vecs[7];
  reg_exp_t sb[$];
  logic [W-1:0] m_y_q;
  logic [1:0]   m_sel_q;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected y for whatever sel the simulator actually holds.
  function automatic logic [W-1:0] model_y();
    logic [W-1:0] r;
    if ($isunknown(bus.sel)) r = {W{1'bx}};
    else begin
      case (bus.sel)
        2'd0: r = bus.d0;
        2'd1: r = bus.d1;
        2'd2: r = bus.d2;
        default: r = bus.d3;
      endcase
    end
    return r;
  endfunction

  // Drive one clock edge: model computes next registered state, pushes it, then compares.
  task automatic tick(input string name);
    reg_exp_t e;
    reg_exp_t got;
    if (rst) begin
      m_y_q = '0; m_sel_q = 2'd0;
    end else if (bus.en) begin
      m_y_q = model_y(); m_sel_q = bus.sel;
    end
    e.y_q = m_y_q; e.sel_q = m_sel_q;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      got = sb.pop_front();
      chk({name, "_y_q"}, bus.y_q, got.y_q);
      chk({name, "_sel_q"}, W'(bus.sel_q), W'(got.sel_q));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] xw;
    xw = {W{1'bx}};

    vecs[0] = '{"abcd_s0", 2'd0, 4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
    vecs[1] = '{"abcd_s1", 2'd1, 4'ha, 4'hb, 4'hc, 4'hd, 4'hb};
    vecs[2] = '{"abcd_s2", 2'd2, 4'ha, 4'hb, 4'hc, 4'hd, 4'hc};
    vecs[3] = '{"abcd_s3", 2'd3, 4'ha, 4'hb, 4'hc, 4'hd, 4'hd};
    vecs[4] = '{"xd3_s0",  2'd0, 4'h7, 4'ha, 4'h3, xw,   4'h7};
    vecs[5] = '{"xd3_s1",  2'd1, 4'h7, 4'ha, 4'h3, xw,   4'ha};
    vecs[6] = '{"xd3_s2",  2'd2, 4'h7, 4'ha, 4'h3, xw,   4'h3};

    rst = 1'b1;
    bus.en = 1'b1;
    bus.sel = 2'd0;
    bus.d0 = 4'h0; bus.d1 = 4'h0; bus.d2 = 4'h0; bus.d3 = 4'h0;
    #2;

    for (int i = 0; i < 7; i++) begin
      bus.sel = vecs[i].sel;
      bus.d0 = vecs[i].d0; bus.d1 = vecs[i].d1;
      bus.d2 = vecs[i].d2; bus.d3 = vecs[i].d3;
      #1;
      chk(vecs[i].name, bus.y, vecs[i].exp_y);
    end

    // Selected input carries X: passes straight through.
    bus.sel = 2'd3;
    #1;
    chk("xd3_s3", bus.y, bus.d3);

    // Unknown select with clean data.
    bus.d3 = 4'hd;
    bus.sel = 2'bxx;
    #1;
    chk("sel_x", bus.y, model_y());

    // Reset with en=1 clears registers.
    @(negedge clk);
    rst = 1'b1; bus.en = 1'b1; bus.sel = 2'd2;
    tick("reset");
    chk("reset_yq_zero", bus.y_q, 4'h0);

    // First capture after reset.
    @(negedge clk);
    rst = 1'b0; bus.en = 1'b1; bus.sel = 2'd1; bus.d1 = 4'hb;
    tick("cap1");
    chk("cap1_yq_b", bus.y_q, 4'hb);

    // Hold with en=0 while combinational path tracks.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.en = 1'b0;
      bus.sel = 2'(k + 2);
      bus.d0 = 4'(k + 1); bus.d2 = 4'(k + 5); bus.d3 = 4'(k + 9);
      #1;
      chk("hold_y_track", bus.y, model_y());
      tick("hold");
    end

    // Several enabled captures with varied data.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.en = 1'b1;
      bus.sel = 2'(3 - k);
      bus.d0 = 4'($urandom_range(0, 15)); bus.d1 = 4'($urandom_range(0, 15));
      bus.d2 = 4'($urandom_range(0, 15)); bus.d3 = 4'($urandom_range(0, 15));
      tick("cap_seq");
    end

    // Mid-operation reset with en=1: reset wins, y unaffected.
    @(negedge clk);
    rst = 1'b1; bus.en = 1'b1; bus.sel = 2'd3; bus.d3 = 4'he;
    tick("mid_reset");
    chk("mid_reset_yq", bus.y_q, 4'h0);
    chk("mid_reset_y", bus.y, 4'he);

    @(negedge clk);
    rst = 1'b0; bus.en = 1'b1; bus.sel = 2'd2; bus.d2 = 4'h6;
    tick("post_reset");

`ifdef MUX4_1_SEL_ONEHOT_EN
    for (int s = 0; s < 4; s++) begin
      logic [3:0] exp_oh;
      exp_oh = 4'b0001 << s;
      bus.sel = 2'(s);
      #1;
      chk("sel_oh", W'(bus.sel_oh), W'(exp_oh));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux4_1_sel.md
Name: mux4_1_sel

Overview:
- 4-to-1 multiplexer, parameterised data width. Combinational output selects one of four data inputs by a 2-bit select index.
- A registered copy of the selected word and of the select is also provided for pipelined consumers.
- Used as a generic datapath selector in DSP blocks.
- The combinational path is the primary, zero-latency output.

Parameters:
- WIDTH, 4, bit width of each data input and of the outputs.

Ports:
- clk    input   1      system clock; all registers update on its rising edge
- rst    input   1      synchronous, active-high reset
- en     input   1      capture enable for the registered outputs
- d0     input   WIDTH  data input 0
- d1     input   WIDTH  data input 1
- d2     input   WIDTH  data input 2
- d3     input   WIDTH  data input 3
- sel    input   2      select index (0..3)
- y      output  WIDTH  combinational selected data
- y_q    output  WIDTH  registered selected data
- sel_q  output  2      registered select index that produced y_q

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- y is purely combinational, with zero latency and no dependence on clk, rst or en.
  - sel=0 -> y=d0; sel=1 -> y=d1; sel=2 -> y=d2; sel=3 -> y=d3.
  - y settles within the same delta/time step as input changes. The bench samples 1 time unit after applying stimulus.
- X propagation:
  - X/Z bits on the selected input appear unchanged on y.
  - X/Z on unselected inputs must never affect y.
  - Implement with a case or index-array selection, not AND-OR logic that could merge X from other inputs.
- sel containing X or Z -> y is all-X (WIDTH bits of X).
- Registered outputs, on the rising clk edge:
  - rst=1: y_q <= 0, sel_q <= 0. Reset has priority over en.
  - rst=0, en=1: y_q <= current combinational y, sel_q <= sel.
  - rst=0, en=0: y_q and sel_q hold their values.
- Latency: y_q and sel_q reflect inputs one clock after capture.
- Reset asserted mid-operation clears y_q and sel_q at the next edge; y is unaffected.
- Before the first clock edge after power-up, y_q and sel_q are undefined. The bench must apply reset first.
- No arithmetic is performed; output width equals WIDTH exactly, with no extension or truncation.

Optional Feature:
- Macro MUX4_1_SEL_ONEHOT_EN.
- When defined, an extra output sel_oh (4 bits, combinational) is present: sel_oh = 1 << sel, e.g. sel=2 -> 0100. sel with X/Z -> sel_oh all-X.
- When not defined, port sel_oh does not exist and there is no related logic.
- All other behaviour is identical in both builds.

Test Plan:
- d0..d3 = a,b,c,d (hex); step sel 0,1,2,3 with checks 1 time unit after each change -> y = a, b, c, d respectively.
- d0=7, d1=10, d2=3, d3=X; sel=0,1,2 -> y = 7, 10, 3 exactly (X on d3 must not leak); sel=3 -> y = X (compare with !==).
- sel=2'bx with valid data inputs -> y all-X.
- rst=1 for one clk edge with en=1 -> y_q=0, sel_q=0. Then rst=0, en=1, sel=1, d1=b -> after the next edge y_q=b, sel_q=1.
- en=0, change sel and data over 3 edges -> y tracks combinationally while y_q/sel_q hold. Assert rst with en=1 at the same edge -> y_q=0, sel_q=0 (reset wins).
- With MUX4_1_SEL_ONEHOT_EN defined: sel=0..3 -> sel_oh = 0001, 0010, 0100, 1000.
